// File: rtl/fetch_pc_unit.sv
// Instruction fetch: owns the PC, one outstanding imem read, valid/ready output buffer.
// Grant to if_valid is 2 cycles on a 1-cycle memory; the buffer holds while if_ready is low.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        BrTaken,
  input  logic        Jump,
  input  logic [31:0] Target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_instr,
  output logic        misalign,
  output logic [31:0] misalign_addr
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] instr_q, instr_d;
  logic        misalign_q, misalign_d;
  logic [31:0] maddr_q, maddr_d;

  logic redir;
  logic tgt_ok;

  assign redir  = BrTaken | Jump;
  assign tgt_ok = (Target[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    ifpc_d     = ifpc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    maddr_d    = maddr_q;

    // The first offending target is kept; HALT ignores everything until reset.
    if (state_q != S_HALT && redir && !tgt_ok) begin
      state_d    = S_HALT;
      misalign_d = 1'b1;
      maddr_d    = Target;
      drop_d     = 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_d = S_REQ;
          if (redir) pc_d = Target;
        end
        S_REQ: begin
          if (redir) pc_d = Target;
          if (imem_gnt) begin
            state_d = S_WAIT;
            drop_d  = redir;
          end
        end
        S_WAIT: begin
          if (redir) begin
            pc_d = Target;
            if (imem_rvalid) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              drop_d = 1'b1;
            end
          end else if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              ifpc_d  = pc_q;
              instr_d = imem_rdata;
              pc_d    = pc_q + 32'd4;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redir) begin
            pc_d    = Target;
            state_d = S_REQ;
          end else if (if_ready) begin
            state_d = S_REQ;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      ifpc_q     <= 32'h0;
      instr_q    <= NOP;
      misalign_q <= 1'b0;
      maddr_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      ifpc_q     <= ifpc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
      maddr_q    <= maddr_d;
    end
  end

  assign imem_req      = (state_q == S_REQ);
  assign imem_addr     = {pc_q[31:2], 2'b00};
  assign if_valid      = (state_q == S_HOLD);
  assign if_pc         = ifpc_q;
  assign if_pc4        = ifpc_q + 32'd4;
  assign if_instr      = instr_q;
  assign misalign      = misalign_q;
  assign misalign_addr = maddr_q;

endmodule
